pipe_ctrl_chain: RTL and testbench

- Parametrised control-path pipeline register chain replacing the fixed per-boundary control registers (Execute→Memory, Memory→Writeback, ...).
- Carries a WIDTH-bit control payload plus a valid bit through DEPTH back-to-back stages.
- Adds a global stall and per-stage flush (bubble insertion) driven by the hazard unit, plus an occupancy count.
- Sits between the hazard unit and the datapath stage boundaries.

---
 rtl/pipe_ctrl_chain_pkg.sv | 15 +
 rtl/pipe_ctrl_chain_stage.sv | 49 ++++
 rtl/pipe_ctrl_chain.sv | 123 ++++++++++++
 tb/tb_pipe_ctrl_chain.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_chain_pkg.sv
// Shared control-path types for the pipeline register chain.
// Default payload packs the Execute->Memory control bits; a bubble is all-zero.
package pipe_pkg;

    typedef struct packed {
        logic       RegWrite;
        logic [1:0] ResultSrc;
        logic       MemWrite;
    } ctrl_em_t;

    localparam int       CTRL_EM_W      = $bits(ctrl_em_t);
    localparam ctrl_em_t CTRL_BUBBLE    = '0;
    localparam int       PIPE_MAX_DEPTH = 8;

endpackage

// File: rtl/pipe_ctrl_chain_stage.sv
// One control register stage: flush beats stall beats shift, 1-cycle latency.
// Stall holds contents; flush loads {0, BUBBLE_VAL}. Also exposes its next-state valid.
module pipe_ctrl_stage
    import pipe_pkg::*;
#(
    parameter int               WIDTH      = CTRL_EM_W,
    parameter logic [WIDTH-1:0] BUBBLE_VAL = WIDTH'(CTRL_BUBBLE)
) (
    input  logic             i_Clk,
    input  logic             i_Reset,
    input  logic             i_PrevValid,
    input  logic [WIDTH-1:0] i_PrevData,
    input  logic             i_Stall,
    input  logic             i_Flush,
    output logic             o_Valid,
    output logic             o_ValidD,
    output logic [WIDTH-1:0] o_Data
);

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q,  data_d;

    always_comb begin
        valid_d = i_PrevValid;
        data_d  = i_PrevData;
        if (i_Flush) begin
            valid_d = 1'b0;
            data_d  = BUBBLE_VAL;
        end else if (i_Stall) begin
            valid_d = valid_q;
            data_d  = data_q;
        end
    end

    always_ff @(posedge i_Clk or negedge i_Reset) begin
        if (!i_Reset) begin
            valid_q <= 1'b0;
            data_q  <= BUBBLE_VAL;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign o_Valid  = valid_q;
    assign o_ValidD = valid_d;
    assign o_Data   = data_q;

endmodule

// File: rtl/pipe_ctrl_chain.sv
// DEPTH-stage control pipeline with global stall, per-stage flush and registered occupancy;
// DEPTH-cycle latency, stall freezes all stages. PIPE_CTRL_PERF_EN adds stall/flush counters.
module pipe_ctrl_chain
    import pipe_pkg::*;
#(
    parameter int               WIDTH      = CTRL_EM_W,
    parameter int               DEPTH      = 2,
    parameter logic [WIDTH-1:0] BUBBLE_VAL = WIDTH'(CTRL_BUBBLE)
) (
    input  logic                       i_Clk,
    input  logic                       i_Reset,
    input  logic [WIDTH-1:0]           i_Data,
    input  logic                       i_Valid,
    input  logic                       i_Stall,
    input  logic [DEPTH-1:0]           i_Flush,
    output logic [WIDTH-1:0]           o_Data,
    output logic                       o_Valid,
    output logic [DEPTH-1:0]           o_StageValid,
    output logic [$clog2(DEPTH+1)-1:0] o_Occupancy
`ifdef PIPE_CTRL_PERF_EN
    ,
    input  logic                       i_PerfClr,
    output logic [31:0]                o_StallCnt,
    output logic [31:0]                o_FlushCnt
`endif
);

    localparam int OCC_W = $clog2(DEPTH+1);

    if (DEPTH < 1 || DEPTH > PIPE_MAX_DEPTH) begin : g_bad_depth
        $error("pipe_ctrl_chain: DEPTH out of range 1..8");
    end

    logic [DEPTH-1:0] vld_q;
    logic [DEPTH-1:0] vld_d;
    logic [WIDTH-1:0] dat_q [DEPTH];

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        logic             prev_vld;
        logic [WIDTH-1:0] prev_dat;

        if (k == 0) begin : g_head
            assign prev_vld = i_Valid;
            assign prev_dat = i_Data;
        end else begin : g_link
            assign prev_vld = vld_q[k-1];
            assign prev_dat = dat_q[k-1];
        end

        pipe_ctrl_stage #(
            .WIDTH      (WIDTH),
            .BUBBLE_VAL (BUBBLE_VAL)
        ) u_stage (
            .i_Clk       (i_Clk),
            .i_Reset     (i_Reset),
            .i_PrevValid (prev_vld),
            .i_PrevData  (prev_dat),
            .i_Stall     (i_Stall),
            .i_Flush     (i_Flush[k]),
            .o_Valid     (vld_q[k]),
            .o_ValidD    (vld_d[k]),
            .o_Data      (dat_q[k])
        );
    end

    // Count the stages' next-state valids so the registered count tracks o_StageValid exactly.
    logic [OCC_W-1:0] occ_q, occ_d;

    always_comb begin
        occ_d = '0;
        for (int k = 0; k < DEPTH; k++) begin
            occ_d = occ_d + OCC_W'(vld_d[k]);
        end
    end

    always_ff @(posedge i_Clk or negedge i_Reset) begin
        if (!i_Reset) begin
            occ_q <= '0;
        end else begin
            occ_q <= occ_d;
        end
    end

    assign o_Data       = dat_q[DEPTH-1];
    assign o_Valid      = vld_q[DEPTH-1];
    assign o_StageValid = vld_q;
    assign o_Occupancy  = occ_q;

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (i_PerfClr) begin
            stall_cnt_d = '0;
            flush_cnt_d = '0;
        end else begin
            if (i_Stall && vld_q[DEPTH-1] && (stall_cnt_q != '1)) begin
                stall_cnt_d = stall_cnt_q + 32'd1;
            end
            if ((|(i_Flush & vld_q)) && (flush_cnt_q != '1)) begin
                flush_cnt_d = flush_cnt_q + 32'd1;
            end
        end
    end

    always_ff @(posedge i_Clk or negedge i_Reset) begin
        if (!i_Reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign o_StallCnt = stall_cnt_q;
    assign o_FlushCnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_ctrl_chain.sv
// Bench for pipe_ctrl_chain at DEPTH=2, WIDTH=4: directed table, reset corners, random model.
module tb_pipe_ctrl_chain;

    localparam int W  = 4;
    localparam int D  = 2;
    localparam int OW = $clog2(D+1);

    logic          clk = 1'b0;
    logic          rst_n;
    logic [W-1:0]  din;
    logic          vin;
    logic          stall;
    logic [D-1:0]  flush;
    logic [W-1:0]  dout;
    logic          vout;
    logic [D-1:0]  sv;
    logic [OW-1:0] occ;
`ifdef PIPE_CTRL_PERF_EN
    logic          perf_clr;
    logic [31:0]   stall_cnt;
    logic [31:0]   flush_cnt;
`endif

    always #5 clk = ~clk;

    pipe_ctrl_chain #(
        .WIDTH      (W),
        .DEPTH      (D),
        .BUBBLE_VAL ('0)
    ) dut (
        .i_Clk        (clk),
        .i_Reset      (rst_n),
        .i_Data       (din),
        .i_Valid      (vin),
        .i_Stall      (stall),
        .i_Flush      (flush),
        .o_Data       (dout),
        .o_Valid      (vout),
        .o_StageValid (sv),
        .o_Occupancy  (occ)
`ifdef PIPE_CTRL_PERF_EN
        ,
        .i_PerfClr    (perf_clr),
        .o_StallCnt   (stall_cnt),
        .o_FlushCnt   (flush_cnt)
`endif
    );

    typedef struct packed {
        logic          vld;
        logic [W-1:0]  dat;
        logic [D-1:0]  sv;
        logic [OW-1:0] occ;
    } exp_t;

    typedef struct {
        logic         vld;
        logic [W-1:0] dat;
        logic         stall;
        logic [D-1:0] flush;
        exp_t         e;
    } vec_t;

    int   n_vec = 0;
    int   n_err = 0;
    exp_t sb[$];
    vec_t tbl[19];

    task automatic check(input string name, input exp_t e);
        n_vec++;
        if ({vout, dout, sv, occ} !== e) begin
            n_err++;
            $display("FAIL %s: got vld=%0b dat=%h sv=%b occ=%0d, want vld=%0b dat=%h sv=%b occ=%0d",
                     name, vout, dout, sv, occ, e.vld, e.dat, e.sv, e.occ);
        end
    endtask

    task automatic check32(input string name, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    task automatic drive(input logic v, input logic [W-1:0] d, input logic s, input logic [D-1:0] f);
        vin   = v;
        din   = d;
        stall = s;
        flush = f;
    endtask

    task automatic step_check(input string name);
        exp_t e;
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check(name, e);
    endtask

    logic         mv [D];
    logic [W-1:0] md [D];

    initial begin
        exp_t         e;
        logic         rv, rs, pv;
        logic [W-1:0] rd, pd;
        logic [D-1:0] rf, msv;
        logic         nv [D];
        logic [W-1:0] nd [D];
        int           cnt;

        // vld, dat, stall, flush | expected after the edge: vld, dat, stage valids, occupancy
        tbl[0]  = '{1'b1, 4'hA, 1'b0, 2'b00, '{1'b0, 4'h0, 2'b01, 2'd1}};
        tbl[1]  = '{1'b1, 4'h5, 1'b0, 2'b00, '{1'b1, 4'hA, 2'b11, 2'd2}};
        tbl[2]  = '{1'b0, 4'h0, 1'b0, 2'b00, '{1'b1, 4'h5, 2'b10, 2'd1}};
        tbl[3]  = '{1'b0, 4'h0, 1'b0, 2'b00, '{1'b0, 4'h0, 2'b00, 2'd0}};
        tbl[4]  = '{1'b1, 4'hA, 1'b0, 2'b00, '{1'b0, 4'h0, 2'b01, 2'd1}};
        tbl[5]  = '{1'b1, 4'h5, 1'b0, 2'b00, '{1'b1, 4'hA, 2'b11, 2'd2}};
        tbl[6]  = '{1'b1, 4'hF, 1'b1, 2'b00, '{1'b1, 4'hA, 2'b11, 2'd2}};
        tbl[7]  = '{1'b1, 4'hF, 1'b1, 2'b00, '{1'b1, 4'hA, 2'b11, 2'd2}};
        tbl[8]  = '{1'b1, 4'hF, 1'b1, 2'b00, '{1'b1, 4'hA, 2'b11, 2'd2}};
        tbl[9]  = '{1'b0, 4'h0, 1'b0, 2'b00, '{1'b1, 4'h5, 2'b10, 2'd1}};
        tbl[10] = '{1'b1, 4'hA, 1'b0, 2'b00, '{1'b0, 4'h0, 2'b01, 2'd1}};
        tbl[11] = '{1'b1, 4'h5, 1'b0, 2'b00, '{1'b1, 4'hA, 2'b11, 2'd2}};
        tbl[12] = '{1'b1, 4'hF, 1'b1, 2'b10, '{1'b0, 4'h0, 2'b01, 2'd1}};
        tbl[13] = '{1'b1, 4'h3, 1'b0, 2'b01, '{1'b1, 4'h5, 2'b10, 2'd1}};
        tbl[14] = '{1'b0, 4'h0, 1'b0, 2'b00, '{1'b0, 4'h0, 2'b00, 2'd0}};
        tbl[15] = '{1'b0, 4'h7, 1'b0, 2'b00, '{1'b0, 4'h0, 2'b00, 2'd0}};
        tbl[16] = '{1'b0, 4'h0, 1'b0, 2'b00, '{1'b0, 4'h7, 2'b00, 2'd0}};
        tbl[17] = '{1'b1, 4'hB, 1'b0, 2'b00, '{1'b0, 4'h0, 2'b01, 2'd1}};
        tbl[18] = '{1'b1, 4'h9, 1'b0, 2'b00, '{1'b1, 4'hB, 2'b11, 2'd2}};

`ifdef PIPE_CTRL_PERF_EN
        perf_clr = 1'b0;
`endif
        rst_n = 1'b0;
        drive(1'b0, 4'h0, 1'b0, 2'b00);
        #1;
        sb.push_back('{1'b0, 4'h0, 2'b00, 2'd0});
        e = sb.pop_front();
        check("reset_state", e);
        #3;
        rst_n = 1'b1;

        for (int i = 0; i < 19; i++) begin
            drive(tbl[i].vld, tbl[i].dat, tbl[i].stall, tbl[i].flush);
            sb.push_back(tbl[i].e);
            step_check($sformatf("table[%0d]", i));
        end

        // Asynchronous reset between edges with the pipeline full.
        drive(1'b1, 4'hC, 1'b0, 2'b00);
        #2;
        rst_n = 1'b0;
        #1;
        sb.push_back('{1'b0, 4'h0, 2'b00, 2'd0});
        e = sb.pop_front();
        check("reset_async", e);
        sb.push_back('{1'b0, 4'h0, 2'b00, 2'd0});
        step_check("reset_hold");
        rst_n = 1'b1;
        drive(1'b1, 4'hD, 1'b0, 2'b00);
        sb.push_back('{1'b0, 4'h0, 2'b01, 2'd1});
        step_check("first_capture");
        drive(1'b0, 4'h0, 1'b0, 2'b00);
        sb.push_back('{1'b1, 4'hD, 2'b10, 2'd1});
        step_check("first_emerge");

        // Random traffic against a behavioural model, starting from reset.
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        for (int k = 0; k < D; k++) begin
            mv[k] = 1'b0;
            md[k] = '0;
        end
        for (int n = 0; n < 400; n++) begin
            rv = 1'($urandom_range(0, 1));
            rd = W'($urandom_range(0, 15));
            rs = ($urandom_range(0, 3) == 0);
            for (int k = 0; k < D; k++) rf[k] = ($urandom_range(0, 5) == 0);
            for (int k = 0; k < D; k++) begin
                pv = (k == 0) ? rv : mv[(k == 0) ? 0 : k-1];
                pd = (k == 0) ? rd : md[(k == 0) ? 0 : k-1];
                if (rf[k]) begin
                    nv[k] = 1'b0;
                    nd[k] = '0;
                end else if (rs) begin
                    nv[k] = mv[k];
                    nd[k] = md[k];
                end else begin
                    nv[k] = pv;
                    nd[k] = pd;
                end
            end
            cnt = 0;
            for (int k = 0; k < D; k++) begin
                mv[k]  = nv[k];
                md[k]  = nd[k];
                msv[k] = nv[k];
                cnt += int'(nv[k]);
            end
            drive(rv, rd, rs, rf);
            sb.push_back('{mv[D-1], md[D-1], msv, OW'(cnt)});
            step_check($sformatf("random[%0d]", n));
        end

`ifdef PIPE_CTRL_PERF_EN
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        drive(1'b0, 4'h0, 1'b0, 2'b00);
        @(posedge clk); #1;
        check32("perf_stall_reset", stall_cnt, 32'd0);
        check32("perf_flush_reset", flush_cnt, 32'd0);
        drive(1'b1, 4'hA, 1'b0, 2'b00);
        @(posedge clk); #1;
        drive(1'b1, 4'h5, 1'b0, 2'b00);
        @(posedge clk); #1;
        for (int n = 0; n < 4; n++) begin
            drive(1'b1, 4'hF, 1'b1, 2'b00);
            @(posedge clk); #1;
        end
        drive(1'b1, 4'hC, 1'b0, 2'b10);
        @(posedge clk); #1;
        drive(1'b0, 4'h0, 1'b0, 2'b01);
        @(posedge clk); #1;
        drive(1'b0, 4'h0, 1'b0, 2'b00);
        check32("perf_stall_cnt", stall_cnt, 32'd4);
        check32("perf_flush_cnt", flush_cnt, 32'd2);
        perf_clr = 1'b1;
        @(posedge clk); #1;
        perf_clr = 1'b0;
        check32("perf_stall_clr", stall_cnt, 32'd0);
        check32("perf_flush_clr", flush_cnt, 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
